ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter CLK_FRE, default 27_000_000: clk frequency in Hz.
REQ-002 SHALL have parameter WS2812_WIDTH, default 24: bits per LED word.
REQ-003 SHALL have parameter BIT_THRESH, default 16: high-pulse cycle count above which a bit decodes as 1 (about 625 ns at 27 MHz).
REQ-004 SHALL have parameter MIN_HIGH, default 4: high pulses shorter than this are errors.
REQ-005 SHALL have parameter MAX_HIGH, default 46: high pulses longer than this are errors.
REQ-006 SHALL have parameter RESET_CYCLES, default 1350: low time marking a reset gap (50 us at 27 MHz).
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port WS2812_IN, input, 1 bit: serial NRZ stream, asynchronous to clk.
REQ-010 SHALL have port WS2812_OUT, output, 1 bit: pass-through for words after the first word of a frame.
REQ-011 SHALL have port data, output, WS2812_WIDTH bits: last fully received word.
REQ-012 SHALL have port data_valid, output, 1 bit: one-cycle pulse when data updates.
REQ-013 SHALL have port word_index, output, 9 bits: index of the word in data within the current frame, starting at 0.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the reset gap ending a frame that contained at least one bit.
REQ-015 SHALL have port bit_err, output, 1 bit: one-cycle pulse on a protocol error.

Function
REQ-016 SHALL pass WS2812_IN through a 2-flop synchronizer to produce din_s; all timing below refers to din_s.
REQ-017 SHALL implement the states WAIT_GAP, IDLE, HIGH and LOW.
REQ-018 WAIT_GAP SHALL count consecutive low cycles; on reaching RESET_CYCLES it SHALL go to IDLE; any high SHALL clear the count.
REQ-019 In IDLE and LOW, a rising edge of din_s SHALL go to HIGH with the high counter set to 1.
REQ-020 HIGH SHALL increment the high counter, saturating at MAX_HIGH+1.
REQ-021 On a falling edge in HIGH, the module SHALL compute the bit as 1 if count > BIT_THRESH, else 0, and SHALL then go to LOW.
REQ-022 On that falling edge, if count < MIN_HIGH, bit_err SHALL pulse, the bit SHALL be discarded and the state SHALL go to WAIT_GAP.
REQ-023 If the high count exceeds MAX_HIGH while in HIGH, bit_err SHALL pulse once and the state SHALL go to WAIT_GAP.
REQ-024 Bits SHALL be assembled LSB first: bit k of a word (k = 0..WS2812_WIDTH-1) lands in shift[k].
REQ-025 On the cycle after the falling edge of bit WS2812_WIDTH-1, data SHALL load the shift register, data_valid SHALL pulse and word_index SHALL show that word's index.
REQ-026 The bit counter SHALL clear on word completion; the word counter SHALL increment and saturate at 511.
REQ-027 LOW SHALL count low cycles; at RESET_CYCLES, frame_done SHALL pulse once, the bit and word counters SHALL clear, and the state SHALL go to IDLE.
REQ-028 If the gap in REQ-027 arrives with a partial word (bit counter nonzero), bit_err SHALL pulse in the same cycle as frame_done and the partial word SHALL be discarded, with no data_valid.
REQ-029 WS2812_OUT SHALL equal din_s delayed by one cycle while the word counter ≥ 1 and the state is HIGH or LOW; otherwise it SHALL be 0.
REQ-030 A gap detected in IDLE with no bits received SHALL produce no frame_done.
REQ-031 data SHALL hold its value between data_valid pulses.

Reset
REQ-032 While rst_n = 0, WS2812_OUT SHALL be 0, data 0, data_valid 0, word_index 0, frame_done 0, bit_err 0, and all counters 0, with state WAIT_GAP.
REQ-033 After rst_n is released, no bit SHALL be accepted before a full RESET_CYCLES low gap, so reset in the middle of a word never yields data_valid.

Verification
REQ-034 Bench SHALL cover: low 1400 cycles, then 24 bits of 0x000001 (1 = high 23/low 10; 0 = high 10/low 23) -> one data_valid, data = 0x000001, word_index = 0, WS2812_OUT stays 0.
REQ-035 Bench SHALL cover: a gap, then 3 words 0x000001, 0x000002, 0x000004, then low 1350 -> three data_valid pulses with word_index 0, 1, 2; WS2812_OUT replicates words 2-3 with 3-cycle latency from WS2812_IN; one frame_done.
REQ-036 Bench SHALL cover: threshold boundary, with high 16 cycles -> bit 0 and high 17 cycles -> bit 1; high 3 cycles -> bit_err; high 47 cycles -> bit_err; after either error, no data_valid until a new gap.
REQ-037 Bench SHALL cover: 10 bits, then low 1350 -> frame_done and bit_err in the same cycle, no data_valid.
REQ-038 Bench SHALL cover: rst_n asserted for 5 cycles after bit 12 of a word, then the stream continues -> all outputs 0; no data_valid until a gap and a complete new word.
REQ-039 Bench SHALL cover: WS2812_IN held high after reset -> state stays WAIT_GAP and no outputs assert.

Source files
------------

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes NRZ high-pulse widths into LED words and
// forwards every word after the first of a frame on WS2812_OUT.
module ws2812_rx #(
    parameter int CLK_FRE      = 27_000_000,
    parameter int WS2812_WIDTH = 24,
    parameter int BIT_THRESH   = 16,
    parameter int MIN_HIGH     = 4,
    parameter int MAX_HIGH     = 46,
    parameter int RESET_CYCLES = 1350
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    WS2812_IN,
    output logic                    WS2812_OUT,
    output logic [WS2812_WIDTH-1:0] data,
    output logic                    data_valid,
    output logic [8:0]              word_index,
    output logic                    frame_done,
    output logic                    bit_err
);

    // Gap counter is sized for at least a 50 us gap at CLK_FRE.
    localparam int GAP_50US = CLK_FRE / 20_000;
    localparam int GAP_MAX  = (GAP_50US > RESET_CYCLES) ? GAP_50US : RESET_CYCLES;
    localparam int LW       = $clog2(GAP_MAX + 1);
    localparam int HW       = $clog2(MAX_HIGH + 2);
    localparam int BW       = (WS2812_WIDTH > 1) ? $clog2(WS2812_WIDTH) : 1;

    localparam logic [LW-1:0] GAP_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [HW-1:0] H_THRESH = HW'(BIT_THRESH);
    localparam logic [HW-1:0] H_MIN    = HW'(MIN_HIGH);
    localparam logic [HW-1:0] H_MAX    = HW'(MAX_HIGH);
    localparam logic [HW-1:0] H_SAT    = HW'(MAX_HIGH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WS2812_WIDTH - 1);

    typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

    state_t                  state;
    logic                    din_m, din_s;
    logic [LW-1:0]           low_cnt;
    logic [HW-1:0]           high_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [8:0]              word_cnt;
    logic [WS2812_WIDTH-1:0] shift;
    logic [WS2812_WIDTH-1:0] word_next;
    logic                    rx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
        end else begin
            din_m <= WS2812_IN;
            din_s <= din_m;
        end
    end

    assign rx_bit = (high_cnt > H_THRESH);

    // NOTE: the default assignment before the indexed write keeps this block latch-free.
    always_comb begin
        word_next          = shift;
        word_next[bit_cnt] = rx_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_GAP;
            low_cnt    <= '0;
            high_cnt   <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shift      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            word_index <= '0;
            frame_done <= 1'b0;
            bit_err    <= 1'b0;
            WS2812_OUT <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only by the branch that needs them.
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            bit_err    <= 1'b0;
            WS2812_OUT <= din_s && (word_cnt != '0) && (state == HIGH || state == LOW);

            case (state)
                WAIT_GAP: begin
                    if (din_s) begin
                        low_cnt <= '0;
                    end else if (low_cnt == GAP_LAST) begin
                        low_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                // IDLE and LOW are only entered with din_s low, so a high level is a rising edge.
                IDLE: begin
                    if (din_s) begin
                        high_cnt <= HW'(1);
                        state    <= HIGH;
                    end
                end

                HIGH: begin
                    if (din_s) begin
                        if (high_cnt >= H_MAX) begin
                            bit_err  <= 1'b1;
                            high_cnt <= H_SAT;
                            low_cnt  <= '0;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                            state    <= WAIT_GAP;
                        end else begin
                            high_cnt <= high_cnt + 1'b1;
                        end
                    end else if (high_cnt < H_MIN) begin
                        bit_err  <= 1'b1;
                        low_cnt  <= '0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        state    <= WAIT_GAP;
                    end else begin
                        // The falling-edge cycle is the first low cycle of the gap count.
                        low_cnt <= LW'(1);
                        state   <= LOW;
                        if (bit_cnt == LAST_BIT) begin
                            data       <= word_next;
                            data_valid <= 1'b1;
                            word_index <= word_cnt;
                            bit_cnt    <= '0;
                            if (word_cnt != 9'd511) word_cnt <= word_cnt + 9'd1;
                        end else begin
                            shift   <= word_next;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                LOW: begin
                    if (din_s) begin
                        high_cnt <= HW'(1);
                        state    <= HIGH;
                    end else if (low_cnt == GAP_LAST) begin
                        frame_done <= 1'b1;
                        bit_err    <= (bit_cnt != '0);
                        bit_cnt    <= '0;
                        word_cnt   <= '0;
                        low_cnt    <= '0;
                        state      <= IDLE;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                default: state <= WAIT_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: expected words go to a scoreboard queue when
// driven and are popped on data_valid; pulse counts are checked per scenario.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ws_in = 1'b0;
    logic        WS2812_OUT;
    logic [23:0] data;
    logic        data_valid;
    logic [8:0]  word_index;
    logic        frame_done;
    logic        bit_err;

    typedef struct {
        logic [23:0] data;
        logic [8:0]  idx;
    } exp_t;

    exp_t        sb[$];
    logic        hist[$];
    logic [23:0] exp_data;
    int          checks, passes, fails;
    int          dv_cnt, fd_cnt, err_cnt, same_cnt;

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .WS2812_IN (ws_in),
        .WS2812_OUT(WS2812_OUT),
        .data      (data),
        .data_valid(data_valid),
        .word_index(word_index),
        .frame_done(frame_done),
        .bit_err   (bit_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock slot: drive, wait for the edge, then sample away from it.
    // hist holds the gated input; a slot's value reaches WS2812_OUT two slots later.
    task automatic tick(input logic v, input logic rep);
        exp_t e;
        ws_in = v;
        hist.push_back(v & rep);
        if (hist.size() > 3) void'(hist.pop_front());
        @(posedge clk);
        #1;
        check("ws2812_out", WS2812_OUT, (hist.size() == 3) ? hist[0] : 1'b0);
        if (data_valid === 1'b1) begin
            dv_cnt++;
            if (sb.size() == 0) begin
                check("data_valid_unexpected", data_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("data", data, e.data);
                check("word_index", word_index, e.idx);
                exp_data = e.data;
            end
        end
        check("data_hold", data, exp_data);
        if (frame_done === 1'b1) fd_cnt++;
        if (bit_err === 1'b1) err_cnt++;
        if (frame_done === 1'b1 && bit_err === 1'b1) same_cnt++;
    endtask

    task automatic pulse(input int h, input int l, input logic rep);
        repeat (h) tick(1'b1, rep);
        repeat (l) tick(1'b0, rep);
    endtask

    task automatic send_bit(input logic b, input logic rep);
        if (b) pulse(23, 10, rep);
        else   pulse(10, 23, rep);
    endtask

    task automatic send_bits(input logic [23:0] w, input int first, input int last, input logic rep);
        for (int k = first; k <= last; k++) send_bit(w[k], rep);
    endtask

    task automatic expect_word(input logic [23:0] w, input logic [8:0] idx);
        exp_t e;
        e.data = w;
        e.idx  = idx;
        sb.push_back(e);
    endtask

    task automatic gap(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        ws_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("reset_outputs",
                  {WS2812_OUT, data_valid, frame_done, bit_err, word_index, data}, 64'd0);
        end
        hist.delete();
        sb.delete();
        exp_data = '0;
        rst_n = 1'b1;
    endtask

    task automatic end_test(input string name, input int dv, input int fd, input int err, input int same);
        gap(5);
        check({name, "_data_valid_count"}, dv_cnt, dv);
        check({name, "_frame_done_count"}, fd_cnt, fd);
        check({name, "_bit_err_count"}, err_cnt, err);
        check({name, "_done_and_err_same_cycle"}, same_cnt, same);
        check({name, "_scoreboard_left"}, sb.size(), 0);
        sb.delete();
        dv_cnt = 0; fd_cnt = 0; err_cnt = 0; same_cnt = 0;
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0;
        dv_cnt = 0; fd_cnt = 0; err_cnt = 0; same_cnt = 0;
        exp_data = '0;

        do_reset(3);

        // Single word after a long gap; first word is never forwarded.
        gap(1400);
        expect_word(24'h000001, 9'd0);
        send_bits(24'h000001, 0, 23, 1'b0);
        gap(1400);
        end_test("single_word", 1, 1, 0, 0);

        // Three words: the second and third are replicated on WS2812_OUT.
        gap(20);
        expect_word(24'h000001, 9'd0);
        expect_word(24'h000002, 9'd1);
        expect_word(24'h000004, 9'd2);
        send_bits(24'h000001, 0, 23, 1'b0);
        send_bits(24'h000002, 0, 23, 1'b1);
        send_bits(24'h000004, 0, 23, 1'b1);
        gap(1350);
        end_test("three_words", 3, 1, 0, 0);

        // Pulse-width boundaries: 17->1, 16->0, 4 (shortest legal)->0, 46 (longest legal)->1.
        gap(1400);
        expect_word(24'h000009, 9'd0);
        pulse(17, 16, 1'b0);
        pulse(16, 17, 1'b0);
        pulse(4, 29, 1'b0);
        pulse(46, 10, 1'b0);
        send_bits(24'h000000, 4, 23, 1'b0);
        gap(1400);
        end_test("threshold", 1, 1, 0, 0);

        // Too-short high: error, then a full word is ignored until a new gap.
        gap(1400);
        send_bits(24'h000000, 0, 4, 1'b0);
        pulse(3, 30, 1'b0);
        send_bits(24'h00A5A5, 0, 23, 1'b0);
        gap(1400);
        end_test("short_high", 0, 0, 1, 0);

        // Too-long high: error, then a full word is ignored until a new gap.
        gap(1400);
        send_bits(24'h000000, 0, 2, 1'b0);
        pulse(47, 10, 1'b0);
        send_bits(24'h000001, 0, 23, 1'b0);
        gap(1400);
        end_test("long_high", 0, 0, 1, 0);

        gap(1400);
        expect_word(24'h00F00F, 9'd0);
        send_bits(24'h00F00F, 0, 23, 1'b0);
        gap(1400);
        end_test("recover", 1, 1, 0, 0);

        // Partial word at the gap: frame_done and bit_err together, nothing delivered.
        gap(1400);
        send_bits(24'h0003FF, 0, 9, 1'b0);
        gap(1350);
        end_test("partial_word", 0, 1, 1, 1);

        // Reset mid-word: nothing accepted until a fresh gap and a complete word.
        gap(1400);
        send_bits(24'hABCDEF, 0, 11, 1'b0);
        do_reset(5);
        send_bits(24'hABCDEF, 12, 23, 1'b0);
        send_bits(24'h123456, 0, 23, 1'b0);
        gap(1400);
        expect_word(24'h5A5A5A, 9'd0);
        send_bits(24'h5A5A5A, 0, 23, 1'b0);
        gap(1400);
        end_test("reset_mid_word", 1, 1, 0, 0);

        // Line stuck high after reset: no outputs at all.
        do_reset(5);
        repeat (2000) tick(1'b1, 1'b0);
        end_test("held_high", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
